// File: rtl/mem_stage_ctrl.sv
// MEM-stage access sequencer: turns EX/MEM M-bits into a req/ack transaction with a
// multi-cycle data memory and stalls the upstream pipeline until it completes or aborts.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  m_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST_C = CNT_W'(TIMEOUT - 1);

  state_t           state_r;
  logic [CNT_W-1:0] tmo_cnt_r;
  logic             op_s;
  logic             illegal_s;
  logic             timeout_s;

  // Decode the pending op and the abort condition for the current cycle.
  always_comb begin
    op_s      = (m_i != 2'b00);
    illegal_s = (m_i == 2'b11) || (addr_i[1:0] != 2'b00);
    timeout_s = (tmo_cnt_r == TMO_LAST_C);
  end

  // Stall is forced low while reset is applied so the pipeline never sees a stale hold.
  assign stall_o = ~rst_i & (((state_r == IDLE) & op_s) | (state_r == BUSY));

  // Transaction sequencer with registered memory-side and result outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      tmo_cnt_r   <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'h0000_0000;
      mem_wdata_o <= 32'h0000_0000;
      rdata_o     <= 32'h0000_0000;
      err_o       <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (op_s) begin
            if (illegal_s) begin
              err_o   <= 1'b1;
              state_r <= DONE;
            end else begin
              mem_req_o   <= 1'b1;
              mem_we_o    <= m_i[0];
              mem_addr_o  <= addr_i;
              mem_wdata_o <= wdata_i;
              tmo_cnt_r   <= '0;
              state_r     <= BUSY;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          // An ack in the final timeout cycle still completes the access normally.
          if (mem_ack_i) begin
            if (!mem_we_o) begin
              rdata_o <= mem_rdata_i;
            end else begin
              rdata_o <= rdata_o;
            end
            mem_req_o <= 1'b0;
            state_r   <= DONE;
          end else if (timeout_s) begin
            mem_req_o <= 1'b0;
            rdata_o   <= 32'h0000_0000;
            err_o     <= 1'b1;
            state_r   <= DONE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          mem_req_o <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= 32'h0000_0000;
    end else if (stall_o && (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end else begin
      stall_cnt_o <= stall_cnt_o;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: per-op expected results are queued when the op is
// driven and compared when the controller reaches its DONE cycle.
module tb_mem_stage_ctrl;

  logic        clk;
  logic        rst_i;
  logic [1:0]  m_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [31:0] stall_cnt_o;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        legal;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb_q[$];
  int   vec_cnt  = 0;
  int   miss_cnt = 0;
  int   exp_stall_total = 0;

  mem_stage_ctrl #(.TIMEOUT(16), .CNT_W(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .m_i         (m_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .stall_o     (stall_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .stall_cnt_o (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drive one op (DUT in IDLE), serve the memory side, finish in the DONE cycle.
  task automatic do_op(input string tag, input logic [1:0] m, input logic [31:0] addr,
                       input logic [31:0] wdata, input int ack_n, input logic [31:0] mrd,
                       input int exp_stall, input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    int   cyc;
    int   k;
    int   first_req;
    m_i     = m;
    addr_i  = addr;
    wdata_i = wdata;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.legal = (m != 2'b11) && (addr[1:0] == 2'b00);
    e.we    = m[0];
    e.addr  = addr;
    e.wdata = wdata;
    sb_q.push_back(e);
    exp_stall_total += exp_stall;
    #1;
    cyc = 0;
    k = 0;
    first_req = -1;
    while (stall_o === 1'b1 && cyc < 64) begin
      if (mem_req_o === 1'b1) begin
        if (first_req < 0) first_req = cyc;
        chk({tag, " we"},    {31'd0, mem_we_o}, {31'd0, e.we});
        chk({tag, " addr"},  mem_addr_o, e.addr);
        chk({tag, " wdata"}, mem_wdata_o, e.wdata);
        if (k == ack_n) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = mrd;
        end
        k++;
      end
      @(posedge clk);
      #1;
      mem_ack_i   = 1'b0;
      mem_rdata_i = 32'h0BAD_0BAD;
      #1;
      cyc++;
    end
    chk({tag, " stall cycles"}, cyc, exp_stall);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, " rdata"}, rdata_o, e.rdata);
      chk({tag, " err"}, {31'd0, err_o}, {31'd0, e.err});
      chk({tag, " first req"}, first_req, e.legal ? 1 : -1);
    end else begin
      chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end
    chk({tag, " req in done"}, {31'd0, mem_req_o}, 32'd0);
    chk({tag, " stall_cnt"}, stall_cnt_o, exp_stall_total);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_i       = 1'b1;
    m_i         = 2'b00;
    addr_i      = 32'h0;
    wdata_i     = 32'h0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst req",       {31'd0, mem_req_o}, 32'd0);
    chk("rst we",        {31'd0, mem_we_o}, 32'd0);
    chk("rst addr",      mem_addr_o, 32'd0);
    chk("rst wdata",     mem_wdata_o, 32'd0);
    chk("rst rdata",     rdata_o, 32'd0);
    chk("rst err",       {31'd0, err_o}, 32'd0);
    chk("rst stall_cnt", stall_cnt_o, 32'd0);
    chk("rst stall",     {31'd0, stall_o}, 32'd0);
    rst_i = 1'b0;
    tick();
    chk("idle stall", {31'd0, stall_o}, 32'd0);

    do_op("t1 load", 2'b10, 32'h0000_0010, 32'h0, 3, 32'hDEAD_BEEF, 5, 32'hDEAD_BEEF, 1'b0);
    m_i = 2'b00; tick();
    do_op("t2 store", 2'b01, 32'h0000_0024, 32'h1234_5678, 1, 32'hCAFE_F00D, 3, 32'hDEAD_BEEF, 1'b0);
    m_i = 2'b00; tick();
    do_op("t3 misaligned", 2'b10, 32'h0000_0013, 32'h0, 0, 32'h0, 1, 32'hDEAD_BEEF, 1'b1);
    m_i = 2'b00; tick();
    chk("t3 err one cycle", {31'd0, err_o}, 32'd0);
    do_op("t3b illegal m", 2'b11, 32'h0000_0020, 32'h0, 0, 32'h0, 1, 32'hDEAD_BEEF, 1'b1);
    m_i = 2'b00; tick();
    do_op("t4 timeout", 2'b10, 32'h0000_0030, 32'h0, -1, 32'h0, 17, 32'h0, 1'b1);
    m_i = 2'b00; tick();
    chk("t4 back to idle stall", {31'd0, stall_o}, 32'd0);
    do_op("t4b load", 2'b10, 32'h0000_0034, 32'h0, 0, 32'h5A5A_1234, 2, 32'h5A5A_1234, 1'b0);
    m_i = 2'b00; tick();

    // Reset lands in the second BUSY cycle; the ack arrives one cycle later.
    m_i    = 2'b10;
    addr_i = 32'h0000_0040;
    tick();
    chk("t5 busy1 req", {31'd0, mem_req_o}, 32'd1);
    tick();
    rst_i = 1'b1;
    #1;
    chk("t5 rst cycle stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_i       = 1'b0;
    m_i         = 2'b00;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hFFFF_0000;
    #1;
    exp_stall_total = 0;
    chk("t5 req",       {31'd0, mem_req_o}, 32'd0);
    chk("t5 we",        {31'd0, mem_we_o}, 32'd0);
    chk("t5 addr",      mem_addr_o, 32'd0);
    chk("t5 rdata",     rdata_o, 32'd0);
    chk("t5 stall_cnt", stall_cnt_o, 32'd0);
    chk("t5 stall",     {31'd0, stall_o}, 32'd0);
    @(posedge clk);
    #1;
    mem_ack_i = 1'b0;
    #1;
    chk("t5 late ack rdata", rdata_o, 32'd0);
    chk("t5 late ack err",   {31'd0, err_o}, 32'd0);
    chk("t5 late ack req",   {31'd0, mem_req_o}, 32'd0);

    // Back-to-back loads with m_i held through the DONE cycle.
    do_op("t6 load a", 2'b10, 32'h0000_0100, 32'h0, 2, 32'h1111_2222, 4, 32'h1111_2222, 1'b0);
    tick();
    chk("t6 no reissue req", {31'd0, mem_req_o}, 32'd0);
    do_op("t6 load b", 2'b10, 32'h0000_0104, 32'h0, 0, 32'h3333_4444, 2, 32'h3333_4444, 1'b0);
    chk("t6 total stall", stall_cnt_o, 32'd6);
    m_i = 2'b00; tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
